// File: rtl/debug_unit.sv
// debug_unit: host-side debug controller for the MIPS core.
// Decodes UART command bytes, loads program words into instruction memory,
// gates pipeline advance through o_step (single step or run-to-end) and
// streams a status byte plus a 304-bit pipeline snapshot back over the UART.
module debug_unit #(
    parameter int NB_DATA = 32,
    parameter int RUN_MAX = 65535
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_we_IF,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic [31:0]        o_instruction_addr,
    output logic               o_step,
    input  logic               i_end,
    input  logic [143:0]       i_seg_ID_EX,
    input  logic [31:0]        i_seg_EX_MEM,
    input  logic [47:0]        i_seg_MEM_WB,
    input  logic [39:0]        i_seg_WB_ID,
    input  logic [23:0]        i_ctrl_ID_EX,
    input  logic [15:0]        i_pc_lsb
);

    // FSM state encoding
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD_CNT   = 4'd1;
    localparam logic [3:0] LOAD_BYTE  = 4'd2;
    localparam logic [3:0] LOAD_WRITE = 4'd3;
    localparam logic [3:0] ACK        = 4'd4;
    localparam logic [3:0] STEP       = 4'd5;
    localparam logic [3:0] RUN        = 4'd6;
    localparam logic [3:0] SNAP       = 4'd7;
    localparam logic [3:0] TX_SEND    = 4'd8;
    localparam logic [3:0] TX_WAIT    = 4'd9;

    // Command and status bytes
    localparam logic [7:0] CMD_LOAD     = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_STEP     = 8'h53;  // 'S'
    localparam logic [7:0] CMD_RUN      = 8'h43;  // 'C'
    localparam logic [7:0] ACK_BYTE     = 8'h4B;  // 'K'
    localparam logic [7:0] STAT_STEP    = 8'h53;  // 'S'
    localparam logic [7:0] STAT_END     = 8'h45;  // 'E'
    localparam logic [7:0] STAT_TIMEOUT = 8'h54;  // 'T'

    localparam int         SNAP_W     = 304;
    localparam logic [5:0] FRAME_LAST = 6'd38;    // index of the final frame byte
    // The counter value seen during the last permitted advance cycle
    localparam logic [15:0] RUN_LAST  = 16'(RUN_MAX - 1);

    logic [3:0]        state;
    logic [7:0]        wordCnt;    // number of words announced by the host
    logic [7:0]        wordIdx;    // index of the word currently being assembled
    logic [1:0]        byteCnt;    // bytes already received for the current word
    logic [23:0]       wordBuf;    // first three bytes of the current word
    logic [15:0]       runCnt;     // advance cycles spent in continuous mode
    logic [7:0]        status;     // frame byte 0
    logic [5:0]        txIdx;      // frame byte currently outstanding
    logic [SNAP_W-1:0] snapshot;   // shifted left one byte per transmitted byte

    // Main controller: command decode, program load, step/run gating, frame transmit
    // NOTE: every register here is assigned with <= so all reads in this block
    // see the pre-edge values, exactly like the flops they become.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state              <= IDLE;
            wordCnt            <= 8'd0;
            wordIdx            <= 8'd0;
            byteCnt            <= 2'd0;
            wordBuf            <= 24'd0;
            runCnt             <= 16'd0;
            status             <= 8'd0;
            txIdx              <= 6'd0;
            // NOTE: the snapshot is a plain register bank, not a RAM, so it is
            // reset like any other state; a stale frame can never leak out.
            snapshot           <= '0;
            o_tx_data          <= 8'h00;
            o_tx_start         <= 1'b0;
            o_we_IF            <= 1'b0;
            o_instruction_data <= '0;
            o_instruction_addr <= 32'd0;
            o_step             <= 1'b1;
        end else begin
            // NOTE: pulse outputs default low here and are raised only by the
            // branch that needs them, so each is high for exactly one cycle.
            o_tx_start <= 1'b0;
            o_we_IF    <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= LOAD_CNT;
                            CMD_STEP: begin
                                state  <= STEP;
                                status <= STAT_STEP;
                                o_step <= 1'b0;
                            end
                            CMD_RUN: begin
                                state  <= RUN;
                                runCnt <= 16'd0;
                                o_step <= 1'b0;
                            end
                            default: ;  // unknown command bytes are ignored
                        endcase
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        wordCnt <= i_rx_data;
                        wordIdx <= 8'd0;
                        byteCnt <= 2'd0;
                        if (i_rx_data == 8'd0) begin
                            state      <= ACK;
                            o_tx_data  <= ACK_BYTE;
                            o_tx_start <= 1'b1;
                        end else begin
                            state <= LOAD_BYTE;
                        end
                    end
                end

                LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        wordBuf <= {wordBuf[15:0], i_rx_data};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            // Big-endian: the first byte received ends up in [31:24]
                            o_instruction_data <= NB_DATA'({wordBuf, i_rx_data});
                            o_instruction_addr <= {22'd0, wordIdx, 2'b00};
                            o_we_IF            <= 1'b1;
                            state              <= LOAD_WRITE;
                        end
                    end
                end

                LOAD_WRITE: begin
                    wordIdx <= wordIdx + 8'd1;
                    if (wordIdx == wordCnt - 8'd1) begin
                        state      <= ACK;
                        o_tx_data  <= ACK_BYTE;
                        o_tx_start <= 1'b1;
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end

                ACK: begin
                    // A done coincident with our own start pulse is not genuine
                    if (!o_tx_start && i_tx_done) begin
                        state <= IDLE;
                    end
                end

                STEP: begin
                    o_step <= 1'b1;
                    state  <= SNAP;
                end

                RUN: begin
                    runCnt <= runCnt + 16'd1;
                    if (i_end) begin
                        status <= STAT_END;
                        o_step <= 1'b1;
                        state  <= SNAP;
                    end else if (runCnt == RUN_LAST) begin
                        status <= STAT_TIMEOUT;
                        o_step <= 1'b1;
                        state  <= SNAP;
                    end
                end

                SNAP: begin
                    snapshot   <= {i_seg_ID_EX, i_seg_EX_MEM, i_seg_MEM_WB,
                                   i_seg_WB_ID, i_ctrl_ID_EX, i_pc_lsb};
                    o_tx_data  <= status;
                    o_tx_start <= 1'b1;
                    txIdx      <= 6'd0;
                    state      <= TX_SEND;
                end

                TX_SEND: begin
                    // Start pulse is on the wire this cycle; any done is ignored
                    state <= TX_WAIT;
                end

                TX_WAIT: begin
                    if (i_tx_done) begin
                        if (txIdx == FRAME_LAST) begin
                            state <= IDLE;
                        end else begin
                            txIdx      <= txIdx + 6'd1;
                            o_tx_data  <= snapshot[SNAP_W-1 -: 8];
                            snapshot   <= {snapshot[SNAP_W-9:0], 8'h00};
                            o_tx_start <= 1'b1;
                            state      <= TX_SEND;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed self-checking bench for debug_unit.
// Two instances: the main one with the default RUN_MAX, and a second one with
// RUN_MAX=8 used only for the continuous-run timeout scenario.
module tb_debug_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         iReset;
    logic [7:0]   rxData;
    logic         rxValid, rxValidT;
    logic         txDone, txDoneT;
    logic         iEnd;
    logic [143:0] segIdEx;
    logic [31:0]  segExMem;
    logic [47:0]  segMemWb;
    logic [39:0]  segWbId;
    logic [23:0]  ctrlIdEx;
    logic [15:0]  pcLsb;

    logic [7:0]  txData, txDataT;
    logic        txStart, txStartT;
    logic        weIF, weIFT;
    logic [31:0] instrData, instrDataT;
    logic [31:0] instrAddr, instrAddrT;
    logic        stepHold, stepHoldT;

    debug_unit dut (
        .clk(clk), .i_reset(iReset),
        .i_rx_data(rxData), .i_rx_valid(rxValid), .i_tx_done(txDone),
        .o_tx_data(txData), .o_tx_start(txStart),
        .o_we_IF(weIF), .o_instruction_data(instrData), .o_instruction_addr(instrAddr),
        .o_step(stepHold), .i_end(iEnd),
        .i_seg_ID_EX(segIdEx), .i_seg_EX_MEM(segExMem), .i_seg_MEM_WB(segMemWb),
        .i_seg_WB_ID(segWbId), .i_ctrl_ID_EX(ctrlIdEx), .i_pc_lsb(pcLsb)
    );

    debug_unit #(.NB_DATA(32), .RUN_MAX(8)) dutT (
        .clk(clk), .i_reset(iReset),
        .i_rx_data(rxData), .i_rx_valid(rxValidT), .i_tx_done(txDoneT),
        .o_tx_data(txDataT), .o_tx_start(txStartT),
        .o_we_IF(weIFT), .o_instruction_data(instrDataT), .o_instruction_addr(instrAddrT),
        .o_step(stepHoldT), .i_end(iEnd),
        .i_seg_ID_EX(segIdEx), .i_seg_EX_MEM(segExMem), .i_seg_MEM_WB(segMemWb),
        .i_seg_WB_ID(segWbId), .i_ctrl_ID_EX(ctrlIdEx), .i_pc_lsb(pcLsb)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit useT       = 1'b0;   // selects which instance the helpers talk to

    wire       curStart = useT ? txStartT : txStart;
    wire [7:0] curData  = useT ? txDataT  : txData;
    wire       curStep  = useT ? stepHoldT : stepHold;

    // Activity counters for the main instance, sampled away from the active edge
    int weCount = 0, txCount = 0, stepLowCount = 0;
    always @(negedge clk) begin
        if (weIF === 1'b1)     weCount++;
        if (txStart === 1'b1)  txCount++;
        if (stepHold === 1'b0) stepLowCount++;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- helpers (stimulus / transmitter model) ----------------

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxData = b;
        if (useT) rxValidT = 1'b1; else rxValid = 1'b1;
        @(negedge clk);
        rxValid  = 1'b0;
        rxValidT = 1'b0;
    endtask

    // Wait (bounded) for a start pulse, capture the byte, optionally inject a
    // stray 'S' while the byte is outstanding, then answer with tx_done.
    task automatic get_byte(input string name, input bit inject,
                            output logic [7:0] b, output int waited);
        waited = 0;
        while (curStart !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (curStart !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no o_tx_start within %0d cycles", name, waited);
            b = 8'h00;
        end else begin
            b = curData;
            if (inject) send_byte(8'h53);
            repeat (3) @(negedge clk);
            if (useT) txDoneT = 1'b1; else txDone = 1'b1;
            @(negedge clk);
            txDone  = 1'b0;
            txDoneT = 1'b0;
        end
    endtask

    // Count consecutive cycles with o_step low; optionally raise i_end on the nth
    task automatic measure_low(input int endAt, output int n);
        n = 0;
        while (curStep === 1'b0 && n < 1000) begin
            n++;
            if (endAt > 0 && n == endAt) iEnd = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic set_pattern(input logic [7:0] s);
        for (int i = 0; i < 18; i++) segIdEx[8*i +: 8] = s + 8'(i);
        segExMem = {4{s ^ 8'hA5}} + 32'h0001_0203;
        segMemWb = {6{~s}};
        segWbId  = {5{s + 8'h40}};
        ctrlIdEx = {3{s ^ 8'h3C}};
        pcLsb    = {s, ~s};
    endtask

    // Receive a whole frame and compare it byte by byte
    task automatic collect_frame(input string name, input logic [7:0] expStatus,
                                 input logic [303:0] expSnap, input int dropAt);
        logic [7:0]  b, expB;
        logic [15:0] lastTwo;
        int          w, extra;
        lastTwo = 16'h0;
        for (int k = 0; k < 39; k++) begin
            get_byte(name, (k == dropAt), b, w);
            if (k == 0) begin
                vectors++;
                if (w !== 1) begin
                    miscompares++;
                    $display("FAIL %s first-start latency: got %0d cycles, expected 1", name, w);
                end
                expB = expStatus;
            end else begin
                expB = expSnap[303 - 8*(k-1) -: 8];
            end
            vectors++;
            if (b !== expB) begin
                miscompares++;
                $display("FAIL %s byte %0d: got %02h expected %02h", name, k, b, expB);
            end
            lastTwo = {lastTwo[7:0], b};
        end
        vectors++;
        if (lastTwo !== pcLsb) begin
            miscompares++;
            $display("FAIL %s trailing pc bytes: got %04h expected %04h", name, lastTwo, pcLsb);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (curStart === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL %s extra tx_start after frame: got %0d expected 0", name, extra);
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        vectors++;
        if ({stepHold, txStart, txData, weIF, instrData, instrAddr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset outputs: step=%b start=%b txd=%02h we=%b data=%08h addr=%08h expected 1 0 00 0 00000000 00000000",
                     stepHold, txStart, txData, weIF, instrData, instrAddr);
        end
        vectors++;
        if ({stepHoldT, txStartT, weIFT} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset timeout-instance: got step/start/we=%b%b%b expected 100",
                     stepHoldT, txStartT, weIFT);
        end
    endtask

    task automatic test_load();
        logic [31:0] words [2];
        logic [7:0]  b;
        int          w, base;
        words[0] = 32'h2001_0005;
        words[1] = 32'h0000_003F;
        base = weCount;
        send_byte(8'h4C);
        send_byte(8'h02);
        for (int wi = 0; wi < 2; wi++) begin
            for (int bi = 0; bi < 4; bi++) send_byte(words[wi][31 - 8*bi -: 8]);
            vectors++;
            if (weIF !== 1'b1 || instrAddr !== 32'(wi * 4) || instrData !== words[wi]) begin
                miscompares++;
                $display("FAIL load write %0d: we=%b addr=%08h data=%08h expected 1 %08h %08h",
                         wi, weIF, instrAddr, instrData, 32'(wi * 4), words[wi]);
            end
            @(negedge clk);
            vectors++;
            if (weIF !== 1'b0 || instrAddr !== 32'(wi * 4) || instrData !== words[wi]) begin
                miscompares++;
                $display("FAIL load hold %0d: we=%b addr=%08h data=%08h expected 0 %08h %08h",
                         wi, weIF, instrAddr, instrData, 32'(wi * 4), words[wi]);
            end
        end
        get_byte("load ack", 1'b0, b, w);
        vectors++;
        if (b !== 8'h4B) begin
            miscompares++;
            $display("FAIL load ack byte: got %02h expected 4b", b);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (weCount - base !== 2) begin
            miscompares++;
            $display("FAIL load write count: got %0d expected 2", weCount - base);
        end
    endtask

    task automatic test_step();
        int n;
        set_pattern(8'h10);
        send_byte(8'h53);
        measure_low(0, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL step low cycles: got %0d expected 1", n);
        end
        collect_frame("step", 8'h53,
                      {segIdEx, segExMem, segMemWb, segWbId, ctrlIdEx, pcLsb}, -1);
    endtask

    task automatic test_run_end();
        int n;
        set_pattern(8'h80);
        send_byte(8'h43);
        measure_low(11, n);
        vectors++;
        if (n !== 11) begin
            miscompares++;
            $display("FAIL run-to-end low cycles: got %0d expected 11", n);
        end
        collect_frame("run end", 8'h45,
                      {segIdEx, segExMem, segMemWb, segWbId, ctrlIdEx, pcLsb}, -1);
        iEnd = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        useT = 1'b1;
        iEnd = 1'b0;
        set_pattern(8'hC3);
        send_byte(8'h43);
        measure_low(0, n);
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL timeout low cycles: got %0d expected 8", n);
        end
        collect_frame("timeout", 8'h54,
                      {segIdEx, segExMem, segMemWb, segWbId, ctrlIdEx, pcLsb}, -1);
        useT = 1'b0;
    endtask

    task automatic test_ignore();
        int baseTx, baseWe, baseStep;
        baseTx = txCount; baseWe = weCount; baseStep = stepLowCount;
        send_byte(8'h7A);
        repeat (20) @(negedge clk);
        vectors++;
        if (txCount !== baseTx || weCount !== baseWe || stepLowCount !== baseStep) begin
            miscompares++;
            $display("FAIL ignore 0x7A: tx/we/steplow deltas %0d %0d %0d expected 0 0 0",
                     txCount - baseTx, weCount - baseWe, stepLowCount - baseStep);
        end
    endtask

    task automatic test_drop_during_frame();
        int n, baseStep;
        set_pattern(8'h5A);
        baseStep = stepLowCount;
        send_byte(8'h53);
        measure_low(0, n);
        collect_frame("drop in frame", 8'h53,
                      {segIdEx, segExMem, segMemWb, segWbId, ctrlIdEx, pcLsb}, 5);
        vectors++;
        if (stepLowCount - baseStep !== 1) begin
            miscompares++;
            $display("FAIL drop in frame step pulses: got %0d low cycles expected 1",
                     stepLowCount - baseStep);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] b;
        int         w, baseWe, baseTx;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h01);
        iReset = 1'b1;
        #1;
        vectors++;
        if ({stepHold, txStart, txData, weIF, instrData, instrAddr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL mid-load reset outputs: step=%b start=%b txd=%02h we=%b data=%08h addr=%08h expected 1 0 00 0 00000000 00000000",
                     stepHold, txStart, txData, weIF, instrData, instrAddr);
        end
        repeat (2) @(negedge clk);
        iReset = 1'b0;
        baseWe = weCount;
        baseTx = txCount;
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) @(negedge clk);
        vectors++;
        if (weCount !== baseWe || txCount !== baseTx) begin
            miscompares++;
            $display("FAIL after reset activity: we/tx deltas %0d %0d expected 0 0",
                     weCount - baseWe, txCount - baseTx);
        end
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        vectors++;
        if (weIF !== 1'b1 || instrAddr !== 32'h0 || instrData !== 32'hAABB_CCDD) begin
            miscompares++;
            $display("FAIL reload write: we=%b addr=%08h data=%08h expected 1 00000000 aabbccdd",
                     weIF, instrAddr, instrData);
        end
        get_byte("reload ack", 1'b0, b, w);
        vectors++;
        if (b !== 8'h4B) begin
            miscompares++;
            $display("FAIL reload ack byte: got %02h expected 4b", b);
        end
        vectors++;
        if (weCount - baseWe !== 1) begin
            miscompares++;
            $display("FAIL reload write count: got %0d expected 1", weCount - baseWe);
        end
    endtask

    initial begin
        iReset   = 1'b1;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        rxValidT = 1'b0;
        txDone   = 1'b0;
        txDoneT  = 1'b0;
        iEnd     = 1'b0;
        set_pattern(8'h00);
        repeat (3) @(negedge clk);
        test_reset();
        iReset = 1'b0;
        repeat (2) @(negedge clk);

        test_load();
        test_step();
        test_run_end();
        test_timeout();
        test_ignore();
        test_drop_during_frame();
        test_reset_mid_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
